risc_run_ctrl: RTL and testbench

- Synthesizable run controller placed beside a RiSC-16 core (non-pipelined or pipelined).
- Generates the core's reset and enable, counts cycles and retired instructions, and supports free-run and single-step modes.
- Detects program halt (branch-to-self spin) and cycle-limit timeout.
- Turns the fixed-delay reset/finish sequencing into reusable, parametrised RTL for benches and FPGA debug.

---
 rtl/risc_run_ctrl_pkg.sv | 24 ++
 rtl/run_spin_detect.sv | 52 +++++
 rtl/risc_run_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_risc_run_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_run_ctrl_pkg.sv
// Shared definitions for the RiSC-16 run controller: run_state encodings, width defaults
// and the RUN_CTRL_BREAKPOINT_EN build option (breakpoint ports and logic when defined).
package risc_run_ctrl_pkg;

    // Machine word width of the RiSC-16 core; the PC default follows it.
    localparam int RISC_WORD_W   = 16;
    localparam int RUN_PC_W_DEF  = RISC_WORD_W;
    localparam int RUN_CNT_W_DEF = 32;

`ifdef RUN_CTRL_BREAKPOINT_EN
    localparam bit RUN_BP_EN = 1'b1;
`else
    localparam bit RUN_BP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_RUN  = 3'd2,
        ST_HALT = 3'd3,
        ST_TMO  = 3'd4
    } run_state_e;

endpackage

// File: rtl/run_spin_detect.sv
// Branch-to-self detector: tracks the PC of the last qualified retire and how many
// consecutive qualified retires have shared it; flags halt when the run reaches SPIN_LIMIT.
module run_spin_detect
    import risc_run_ctrl_pkg::*;
#(
    parameter int PC_W       = RUN_PC_W_DEF,
    parameter int SPIN_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            retire_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            halt_o
);

    localparam int SPIN_W = $clog2(SPIN_LIMIT + 1);
    localparam logic [SPIN_W-1:0] SPIN_MAX = SPIN_W'(SPIN_LIMIT);

    logic [PC_W-1:0]   last_pc_q, last_pc_d;
    logic [SPIN_W-1:0] spin_q, spin_d;

    always_comb begin
        last_pc_d = last_pc_q;
        spin_d    = spin_q;
        if (clear_i) begin
            last_pc_d = '0;
            spin_d    = '0;
        end else if (retire_i) begin
            last_pc_d = pc_i;
            if (pc_i != last_pc_q) begin
                spin_d = SPIN_W'(1);
            end else if (spin_q != SPIN_MAX) begin
                spin_d = spin_q + SPIN_W'(1);
            end
        end
    end

    // Halt is reported in the cycle of the retire that completes the run of repeats.
    assign halt_o = retire_i && !clear_i && (spin_d == SPIN_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pc_q <= '0;
            spin_q    <= '0;
        end else begin
            last_pc_q <= last_pc_d;
            spin_q    <= spin_d;
        end
    end

endmodule

// File: rtl/risc_run_ctrl.sv
// Run controller beside a RiSC-16 core: core reset/enable sequencing, free-run and single-step,
// cycle/retire counters, spin-halt and timeout detection. RUN_CTRL_BREAKPOINT_EN adds a PC breakpoint.
module risc_run_ctrl
    import risc_run_ctrl_pkg::*;
#(
    parameter int PC_W         = RUN_PC_W_DEF,
    parameter int CNT_W        = RUN_CNT_W_DEF,
    parameter int RESET_CYCLES = 2,
    parameter int MAX_CYCLES   = 300,
    parameter int SPIN_LIMIT   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic [PC_W-1:0]  core_pc,
    input  logic             core_retire,
`ifdef RUN_CTRL_BREAKPOINT_EN
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_valid,
    output logic             bp_hit,
`endif
    output logic             core_reset,
    output logic             core_en,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retire_count,
    output logic             halted,
    output logic             timed_out,
    output logic [2:0]       run_state
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CYC_LIMIT = CNT_W'(MAX_CYCLES);

    run_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              step_q;
    logic              core_reset_q, core_reset_d;
    logic              core_en_q, core_en_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d, cycle_inc;
    logic [CNT_W-1:0]  retire_q, retire_d, retire_inc;
    logic              halted_q, halted_d;
    logic              timed_out_q, timed_out_d;

    logic retire_ok, step_edge, start_ok, spin_halt, bp_active, run_en, timeout_hit;

    // A retire only counts when the core was actually enabled in that cycle.
    assign retire_ok = core_retire & core_en_q;
    assign step_edge = step_req & ~step_q;
    assign start_ok  = start & ((state_q == ST_IDLE) || (state_q == ST_HALT) || (state_q == ST_TMO));

    assign cycle_inc  = (core_en_q && (cycle_q != '1)) ? cycle_q + CNT_W'(1) : cycle_q;
    assign retire_inc = (retire_ok && (retire_q != '1)) ? retire_q + CNT_W'(1) : retire_q;
    assign timeout_hit = core_en_q && (cycle_inc == CYC_LIMIT);

    // In step behaviour the enable is a one-cycle pulse following a step_req rising edge.
    assign run_en = (step_mode | bp_active) ? step_edge : 1'b1;

    run_spin_detect #(
        .PC_W       (PC_W),
        .SPIN_LIMIT (SPIN_LIMIT)
    ) u_spin (
        .clk      (clk),
        .rst      (reset),
        .clear_i  (start_ok),
        .retire_i (retire_ok),
        .pc_i     (core_pc),
        .halt_o   (spin_halt)
    );

`ifdef RUN_CTRL_BREAKPOINT_EN
    logic bp_set, bp_hit_q, bp_hit_d;

    assign bp_set    = retire_ok & bp_valid & (core_pc == bp_addr);
    assign bp_active = bp_hit_q | bp_set;

    always_comb begin
        bp_hit_d = bp_hit_q;
        if (start_ok) begin
            bp_hit_d = 1'b0;
        end else if (bp_set) begin
            bp_hit_d = 1'b1;
        end else if ((state_q == ST_RUN) && step_edge) begin
            bp_hit_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp_hit_q <= 1'b0;
        end else begin
            bp_hit_q <= bp_hit_d;
        end
    end

    assign bp_hit = bp_hit_q;
`else
    assign bp_active = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        core_en_d   = 1'b0;
        cycle_d     = cycle_inc;
        retire_d    = retire_inc;
        halted_d    = halted_q;
        timed_out_d = timed_out_q;
        unique case (state_q)
            ST_IDLE, ST_HALT, ST_TMO: begin
                if (start_ok) begin
                    state_d     = ST_HOLD;
                    hold_d      = HOLD_LOAD;
                    cycle_d     = '0;
                    retire_d    = '0;
                    halted_d    = 1'b0;
                    timed_out_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (hold_q == '0) begin
                    state_d   = ST_RUN;
                    core_en_d = run_en;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_RUN: begin
                // Spin halt takes precedence over a timeout landing on the same cycle.
                if (spin_halt) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d     = ST_TMO;
                    timed_out_d = 1'b1;
                end else begin
                    core_en_d = run_en;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        core_reset_d = (state_d == ST_IDLE) || (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            step_q       <= 1'b0;
            core_reset_q <= 1'b1;
            core_en_q    <= 1'b0;
            cycle_q      <= '0;
            retire_q     <= '0;
            halted_q     <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            step_q       <= step_req;
            core_reset_q <= core_reset_d;
            core_en_q    <= core_en_d;
            cycle_q      <= cycle_d;
            retire_q     <= retire_d;
            halted_q     <= halted_d;
            timed_out_q  <= timed_out_d;
        end
    end

    assign core_reset   = core_reset_q;
    assign core_en      = core_en_q;
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;
    assign halted       = halted_q;
    assign timed_out    = timed_out_q;
    assign run_state    = state_q;

endmodule

// File: tb/tb_risc_run_ctrl.sv
// Bench for risc_run_ctrl: directed scenarios plus randomized traffic, checked cycle by cycle
// against a behavioural model through an expected-value queue.
module tb_risc_run_ctrl;

    localparam int PC_W         = 16;
    localparam int CNT_W        = 32;
    localparam int RESET_CYCLES = 2;
    localparam int MAX_CYCLES   = 20;
    localparam int SPIN_LIMIT   = 4;
    localparam int EXP_W        = 71;
    localparam longint CNT_MAX  = 64'h0000_0000_FFFF_FFFF;

    localparam int S_IDLE = 0;
    localparam int S_HOLD = 1;
    localparam int S_RUN  = 2;
    localparam int S_HALT = 3;
    localparam int S_TMO  = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic             step_mode;
    logic             step_req;
    logic [PC_W-1:0]  core_pc;
    logic             core_retire;
    logic             core_reset;
    logic             core_en;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;
    logic             halted;
    logic             timed_out;
    logic [2:0]       run_state;

    int checks   = 0;
    int failures = 0;
    logic [EXP_W-1:0] exp_q[$];

    int              m_state;
    int              m_hold;
    int              m_spin;
    bit              m_rst;
    bit              m_en;
    bit              m_halt;
    bit              m_tmo;
    bit              m_prev_req;
    longint          m_cyc;
    longint          m_ret;
    logic [PC_W-1:0] m_last;

    risc_run_ctrl #(
        .PC_W         (PC_W),
        .CNT_W        (CNT_W),
        .RESET_CYCLES (RESET_CYCLES),
        .MAX_CYCLES   (MAX_CYCLES),
        .SPIN_LIMIT   (SPIN_LIMIT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .step_mode    (step_mode),
        .step_req     (step_req),
        .core_pc      (core_pc),
        .core_retire  (core_retire),
        .core_reset   (core_reset),
        .core_en      (core_en),
        .cycle_count  (cycle_count),
        .retire_count (retire_count),
        .halted       (halted),
        .timed_out    (timed_out),
        .run_state    (run_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the controller should show in the cycle after each clock edge.
    task automatic model_reset();
        m_state = S_IDLE; m_hold = 0; m_spin = 0;
        m_rst = 1'b1; m_en = 1'b0; m_halt = 1'b0; m_tmo = 1'b0; m_prev_req = 1'b0;
        m_cyc = 0; m_ret = 0; m_last = '0;
    endtask

    task automatic model_clock();
        bit rising, qual, halt_now, want_en;
        rising     = step_req && !m_prev_req;
        m_prev_req = step_req;
        qual       = core_retire && m_en;
        halt_now   = 1'b0;
        if (m_en && m_cyc < CNT_MAX) m_cyc++;
        if (qual) begin
            if (m_ret < CNT_MAX) m_ret++;
            if (core_pc == m_last) begin
                if (m_spin < SPIN_LIMIT) m_spin++;
            end else begin
                m_spin = 1;
            end
            m_last   = core_pc;
            halt_now = (m_spin == SPIN_LIMIT);
        end
        want_en = step_mode ? rising : 1'b1;
        m_en    = 1'b0;
        case (m_state)
            S_IDLE, S_HALT, S_TMO: begin
                if (start) begin
                    m_state = S_HOLD; m_hold = RESET_CYCLES;
                    m_cyc = 0; m_ret = 0; m_halt = 1'b0; m_tmo = 1'b0;
                    m_spin = 0; m_last = '0;
                end
            end
            S_HOLD: begin
                m_hold--;
                if (m_hold == 0) begin
                    m_state = S_RUN;
                    m_en    = want_en;
                end
            end
            S_RUN: begin
                if (halt_now) begin
                    m_state = S_HALT; m_halt = 1'b1;
                end else if (m_cyc == MAX_CYCLES) begin
                    m_state = S_TMO; m_tmo = 1'b1;
                end else begin
                    m_en = want_en;
                end
            end
            default: m_state = S_IDLE;
        endcase
        m_rst = (m_state == S_IDLE) || (m_state == S_HOLD);
    endtask

    function automatic logic [EXP_W-1:0] model_snapshot();
        logic [CNT_W-1:0] c, r;
        logic [2:0] s;
        c = CNT_W'(m_cyc);
        r = CNT_W'(m_ret);
        s = 3'(m_state);
        return {m_rst, m_en, c, r, m_halt, m_tmo, s};
    endfunction

    task automatic model_loop();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_reset();
                exp_q.delete();
            end else begin
                model_clock();
            end
            exp_q.push_back(model_snapshot());
        end
    endtask

    task automatic monitor_loop();
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mon_core_reset",   32'(core_reset),  32'(e[70]));
                chk("mon_core_en",      32'(core_en),     32'(e[69]));
                chk("mon_cycle_count",  cycle_count,      e[68:37]);
                chk("mon_retire_count", retire_count,     e[36:5]);
                chk("mon_halted",       32'(halted),      32'(e[4]));
                chk("mon_timed_out",    32'(timed_out),   32'(e[3]));
                chk("mon_run_state",    32'(run_state),   32'(e[2:0]));
            end
        end
    endtask

    task automatic watchdog();
        #500000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_en(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (core_en === 1'b1) break;
            tick();
        end
        chk("wait_core_en", 32'(core_en), 32'd1);
    endtask

    initial begin
        logic [PC_W-1:0] spin_pcs[7];
        logic [PC_W-1:0] pc;

        reset = 1'b1; start = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        core_retire = 1'b0; core_pc = '0;
        fork
            model_loop();
            monitor_loop();
            watchdog();
        join_none

        // Reset values, then basic start sequence.
        do_reset(2);
        chk("rst_state", 32'(run_state), S_IDLE);
        chk("rst_core_reset", 32'(core_reset), 1);
        chk("rst_core_en", 32'(core_en), 0);
        chk("rst_cycle_count", cycle_count, 0);
        pulse_start();
        chk("basic_hold1_state", 32'(run_state), S_HOLD);
        chk("basic_hold1_reset", 32'(core_reset), 1);
        tick();
        chk("basic_hold2_state", 32'(run_state), S_HOLD);
        tick();
        chk("basic_run_state", 32'(run_state), S_RUN);
        chk("basic_run_en", 32'(core_en), 1);
        chk("basic_run_reset", 32'(core_reset), 0);

        // Spin halt on repeated PC 3.
        spin_pcs = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3};
        for (int i = 0; i < 7; i++) begin
            core_retire = 1'b1;
            core_pc = spin_pcs[i];
            tick();
        end
        core_retire = 1'b0;
        chk("spin_halted", 32'(halted), 1);
        chk("spin_retire_count", retire_count, 7);
        chk("spin_core_en", 32'(core_en), 0);
        chk("spin_state", 32'(run_state), S_HALT);
        tick();

        // Timeout with never-repeating PCs.
        pulse_start();
        wait_en(10);
        pc = 16'h0100;
        for (int n = 0; n < 60; n++) begin
            if (timed_out === 1'b1) break;
            core_retire = 1'($urandom_range(0, 1));
            core_pc = pc;
            pc = pc + 16'd1;
            tick();
        end
        core_retire = 1'b0;
        chk("tmo_timed_out", 32'(timed_out), 1);
        chk("tmo_cycle_count", cycle_count, MAX_CYCLES);
        chk("tmo_state", 32'(run_state), S_TMO);
        chk("tmo_halted", 32'(halted), 0);

        // Spin limit and cycle limit reached on the same edge.
        pulse_start();
        wait_en(10);
        for (int k = 1; k <= 20; k++) begin
            core_retire = 1'b1;
            core_pc = (k <= 16) ? PC_W'(16'h0200 + k) : 16'h0007;
            tick();
        end
        core_retire = 1'b0;
        chk("simul_halted", 32'(halted), 1);
        chk("simul_timed_out", 32'(timed_out), 0);
        chk("simul_state", 32'(run_state), S_HALT);
        chk("simul_cycle_count", cycle_count, 20);

        // Single step: held request gives one enable pulse.
        step_mode = 1'b1;
        pulse_start();
        repeat (3) tick();
        chk("step_idle_en", 32'(core_en), 0);
        chk("step_idle_cycles", cycle_count, 0);
        step_req = 1'b1;
        repeat (5) tick();
        step_req = 1'b0;
        repeat (3) tick();
        chk("step_one", cycle_count, 1);
        step_req = 1'b1;
        repeat (2) tick();
        step_req = 1'b0;
        repeat (2) tick();
        chk("step_two", cycle_count, 2);

        // Free-run then asynchronous reset mid-run.
        step_mode = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (cycle_count >= 10) break;
            tick();
        end
        chk("midrun_cycles", cycle_count, 10);
        #1;
        reset = 1'b1;
        #1;
        chk("midrun_core_reset", 32'(core_reset), 1);
        chk("midrun_core_en", 32'(core_en), 0);
        chk("midrun_cycle_count", cycle_count, 0);
        chk("midrun_state", 32'(run_state), S_IDLE);
        tick();
        tick();
        reset = 1'b0;
        pulse_start();
        wait_en(10);
        chk("restart_cycles", cycle_count, 0);
        chk("restart_retires", retire_count, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            start = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 29) == 0) step_mode = ~step_mode;
            if ($urandom_range(0, 2) == 0) step_req = ~step_req;
            core_retire = 1'($urandom_range(0, 1));
            core_pc = PC_W'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) do_reset(1);
            else tick();
        end
        start = 1'b0; step_req = 1'b0; core_retire = 1'b0;
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
